// File: rtl/spi_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl_if
//   Bundles the request/response handshake and the SPI pins of
//   spi_master_ctrl.
//
//   Handshake: a request is taken on a rising clk edge when start=1 and
//   ready=1. slave_id and tx_data are sampled on that same edge. While
//   ready=0, start is ignored and nothing is queued. rx_valid and err are
//   single-cycle pulses, and no acknowledge is expected for them.
//
//   modport master : the controller itself (drives the SPI pins and the
//                    status/response signals).
//   modport slave  : everything around it (request logic plus the SPI slave
//                    that returns miso).
//
//   Signals
//     start     request strobe            slave_id  target slave index
//     tx_data   word to send              abort     cancel active transfer
//     ready     idle, request accepted    busy      transfer in progress
//     rx_data   last received word        rx_valid  rx_data updated (pulse)
//     err       request rejected (pulse)  sclk      SPI clock, idle low
//     mosi      master-out data           miso      slave-out data
//     ss        selected slave, N_SLAVES = none
// -----------------------------------------------------------------------------
interface spi_master_ctrl_if #(
   parameter int WIDTH    = 8,
   parameter int N_SLAVES = 4,
   parameter int SS_W     = $clog2(N_SLAVES + 1)
);
   logic             start;
   logic [SS_W-1:0]  slave_id;
   logic [WIDTH-1:0] tx_data;
   logic             abort;
   logic             ready;
   logic             busy;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             err;
   logic             sclk;
   logic             mosi;
   logic             miso;
   logic [SS_W-1:0]  ss;

   modport master (
      input  start, slave_id, tx_data, abort, miso,
      output ready, busy, rx_data, rx_valid, err, sclk, mosi, ss
   );

   modport slave (
      output start, slave_id, tx_data, abort, miso,
      input  ready, busy, rx_data, rx_valid, err, sclk, mosi, ss
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   SPI mode-0 bus master. Each accepted request runs one full-duplex,
//   MSB-first transfer of WIDTH bits to the slave picked by slave_id. sclk is
//   derived from clk by division: every half-period lasts CLK_DIV clk cycles.
//
//   Ports
//     clk        system clock
//     rst        synchronous, active-high reset
//     bus        spi_master_ctrl_if.master (handshake, status, SPI pins)
//     state_dbg  current FSM state (0 IDLE, 1 XFER, 2 HOLD)
//
//   Transfer timeline (E0 = edge that accepts start)
//     E0                       ss, mosi=tx[MSB], busy valid
//     E0+(2k+1)*CLK_DIV        k-th sclk rise
//     E0+(2k+2)*CLK_DIV        sclk fall, miso sampled, mosi advances
//     E0+2*WIDTH*CLK_DIV       last fall, enter HOLD (ss kept)
//     E0+(2*WIDTH+1)*CLK_DIV   ss released, rx_valid pulse, back to IDLE
//
//   Every output is a register.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int WIDTH    = 8,
   parameter int N_SLAVES = 4,
   parameter int CLK_DIV  = 2,
   parameter int SS_W     = $clog2(N_SLAVES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_master_ctrl_if.master      bus,
   output logic [1:0]             state_dbg
);

   // The phase counter needs at least one bit, even when CLK_DIV=1.
   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [SS_W-1:0]  SS_NONE  = SS_W'(N_SLAVES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [PH_W-1:0]  ph_cnt;   // clk cycles spent in the current sclk phase
   logic [BIT_W-1:0] bit_cnt;  // index of the bit being transferred
   logic [WIDTH-1:0] tx_sh;    // MSB is always the bit currently on mosi
   logic [WIDTH-1:0] rx_sh;    // miso bits shift in at the LSB

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ph_cnt       <= '0;
         bit_cnt      <= '0;
         tx_sh        <= '0;
         rx_sh        <= '0;
         bus.sclk     <= 1'b0;
         bus.mosi     <= 1'b0;
         bus.ss       <= SS_NONE;
         bus.ready    <= 1'b1;
         bus.busy     <= 1'b0;
         bus.rx_data  <= '0;
         bus.rx_valid <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         // Both pulses last one cycle unless a branch below sets them again.
         bus.rx_valid <= 1'b0;
         bus.err      <= 1'b0;

         case (state)
            IDLE: begin
               // start wins over abort here, because abort has nothing to cancel.
               if (bus.start) begin
                  if (bus.slave_id < SS_NONE) begin
                     tx_sh     <= bus.tx_data;
                     rx_sh     <= '0;
                     bus.ss    <= bus.slave_id;
                     bus.mosi  <= bus.tx_data[WIDTH-1];
                     bus.sclk  <= 1'b0;
                     ph_cnt    <= '0;
                     bit_cnt   <= '0;
                     bus.ready <= 1'b0;
                     bus.busy  <= 1'b1;
                     state     <= XFER;
                  end else begin
                     // Out-of-range slave: the request is refused and the
                     // bus stays untouched.
                     bus.err <= 1'b1;
                  end
               end
            end

            XFER: begin
               if (bus.abort) begin
                  state     <= IDLE;
                  ph_cnt    <= '0;
                  bit_cnt   <= '0;
                  bus.sclk  <= 1'b0;
                  bus.mosi  <= 1'b0;
                  bus.ss    <= SS_NONE;
                  bus.ready <= 1'b1;
                  bus.busy  <= 1'b0;
               end else if (ph_cnt != PH_LAST) begin
                  ph_cnt <= ph_cnt + PH_W'(1);
               end else begin
                  ph_cnt <= '0;
                  if (!bus.sclk) begin
                     // Low phase done: rising edge, the slave samples mosi.
                     bus.sclk <= 1'b1;
                  end else begin
                     // High phase done: falling edge. Capture miso here,
                     // because the slave only changes it after this edge.
                     bus.sclk <= 1'b0;
                     rx_sh    <= {rx_sh[WIDTH-2:0], bus.miso};
                     if (bit_cnt == BIT_LAST) begin
                        // mosi keeps the last bit through HOLD.
                        state <= HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        tx_sh    <= {tx_sh[WIDTH-2:0], 1'b0};
                        bus.mosi <= tx_sh[WIDTH-2];
                     end
                  end
               end
            end

            HOLD: begin
               if (bus.abort) begin
                  state     <= IDLE;
                  ph_cnt    <= '0;
                  bit_cnt   <= '0;
                  bus.sclk  <= 1'b0;
                  bus.mosi  <= 1'b0;
                  bus.ss    <= SS_NONE;
                  bus.ready <= 1'b1;
                  bus.busy  <= 1'b0;
               end else if (ph_cnt != PH_LAST) begin
                  ph_cnt <= ph_cnt + PH_W'(1);
               end else begin
                  // ss stays asserted for one extra half-period after the last
                  // fall. The slave then has a full sclk-low interval before
                  // deselect.
                  state        <= IDLE;
                  ph_cnt       <= '0;
                  bit_cnt      <= '0;
                  bus.ss       <= SS_NONE;
                  bus.mosi     <= 1'b0;
                  bus.rx_data  <= rx_sh;
                  bus.rx_valid <= 1'b1;
                  bus.ready    <= 1'b1;
                  bus.busy     <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               ph_cnt    <= '0;
               bit_cnt   <= '0;
               bus.sclk  <= 1'b0;
               bus.mosi  <= 1'b0;
               bus.ss    <= SS_NONE;
               bus.ready <= 1'b1;
               bus.busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Drives spi_master_ctrl through its interface, with a behavioural SPI slave
//   that returns a chosen word. The driver pushes the expected outcome of each
//   request into exp_q. A monitor rebuilds each finished transfer from the
//   pins (the mosi bits at sclk rises, the rise count and the selected slave)
//   and checks it, together with rx_data and completion time, against the
//   head of the queue.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;
   localparam int W      = 8;
   localparam int N      = 4;
   localparam int CD     = 2;
   localparam int SS_W   = $clog2(N + 1);
   localparam int PERIOD = (2 * W + 1) * CD;  // E0 to the rx_valid edge

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state_dbg;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_master_ctrl_if #(.WIDTH(W), .N_SLAVES(N)) bus ();

   spi_master_ctrl #(.WIDTH(W), .N_SLAVES(N), .CLK_DIV(CD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      int          id;
      logic [W-1:0] tx;
      logic [W-1:0] rx;
      int unsigned cyc;
   } exp_t;

   exp_t         exp_q[$];
   int           errors = 0;
   int           checks = 0;
   int           err_exp = 0;
   int           err_seen = 0;
   logic [W-1:0] slave_word [N];
   logic [W-1:0] last_rx = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- SPI slave model ----------------
   // Mode 0: bit k goes out after k falling edges of sclk, MSB first.
   int   fall_cnt = 0;
   logic s_prev_sclk = 1'b0;
   always @(negedge clk) begin
      int sid;
      sid = int'(bus.ss);
      if (sid >= N) fall_cnt = 0;
      else if (s_prev_sclk && !bus.sclk) fall_cnt++;
      s_prev_sclk = bus.sclk;
      if (sid < N && fall_cnt < W) bus.miso = slave_word[sid][W-1-fall_cnt];
      else bus.miso = 1'b0;
   end

   // ---------------- monitor ----------------
   logic            m_prev_sclk = 1'b0;
   logic            m_prev_busy = 1'b0;
   logic [SS_W-1:0] m_prev_ss = SS_W'(N);
   logic            abort_prev = 1'b0;
   logic            rst_prev = 1'b1;
   logic [W-1:0]    mosi_acc = '0;
   int              rise_cnt = 0;
   logic [SS_W-1:0] xfer_ss = '0;
   logic            ss_bad = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (bus.err) err_seen++;
      if (rst) last_rx = '0;
      if (!rst_prev) begin
         if (bus.busy && !m_prev_busy) begin
            rise_cnt = 0;
            mosi_acc = '0;
            ss_bad   = 1'b0;
            xfer_ss  = bus.ss;
         end
         if (bus.sclk && !m_prev_sclk) begin
            mosi_acc = {mosi_acc[W-2:0], bus.mosi};
            rise_cnt++;
            if (bus.ss !== xfer_ss) ss_bad = 1'b1;
         end
         // Outside an abort, ss may only move while sclk was low.
         if (bus.ss !== m_prev_ss && !abort_prev)
            chk("ss_change_sclk_low", m_prev_sclk, 0);
         if (bus.rx_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rx_valid: got rx_valid=1 expected no transfer (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("rx_data", bus.rx_data, e.rx);
               chk("mosi_stream", mosi_acc, e.tx);
               chk("sclk_rises", rise_cnt, W);
               chk("ss_during_xfer", xfer_ss, e.id);
               chk("ss_stable", ss_bad, 0);
               chk("rx_valid_cycle", e.cyc, cyc);
               chk("ss_released", bus.ss, N);
               chk("ready_at_done", bus.ready, 1);
               last_rx = e.rx;
            end
         end
      end
      m_prev_sclk = bus.sclk;
      m_prev_busy = bus.busy;
      m_prev_ss   = bus.ss;
      abort_prev  = bus.abort;
      rst_prev    = rst;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.ready) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: got ready=0 expected 1 within 200 cycles");
      end
   endtask

   // Issues one request to a legal slave. keep leaves start high afterwards.
   task automatic issue(input int id, input logic [W-1:0] tx, input logic [W-1:0] sw,
                        input bit expect_done, input bit keep);
      exp_t e;
      wait_ready();
      slave_word[id] = sw;
      bus.start    = 1'b1;
      bus.slave_id = SS_W'(id);
      bus.tx_data  = tx;
      if (expect_done) begin
         e.id  = id;
         e.tx  = tx;
         e.rx  = sw;
         e.cyc = cyc + 1 + PERIOD;
         exp_q.push_back(e);
      end
      tick();
      if (!keep) bus.start = 1'b0;
   endtask

   task automatic issue_bad(input int id);
      wait_ready();
      bus.start    = 1'b1;
      bus.slave_id = SS_W'(id);
      bus.tx_data  = W'($urandom);
      err_exp++;
      tick();
      bus.start = 1'b0;
      chk("err_pulse", bus.err, 1);
      chk("err_ss_idle", bus.ss, N);
      chk("err_ready", bus.ready, 1);
      chk("err_sclk", bus.sclk, 0);
      tick();
      chk("err_one_cycle", bus.err, 0);
      chk("err_sclk_after", bus.sclk, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending transfers expected 0", exp_q.size());
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.start    = 1'b0;
      bus.slave_id = '0;
      bus.tx_data  = '0;
      bus.abort    = 1'b0;
      for (int i = 0; i < N; i++) slave_word[i] = '0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state, then ten quiet idle cycles.
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_mosi", bus.mosi, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_sclk", bus.sclk, 0);
         chk("idle_ss", bus.ss, N);
         chk("idle_ready", bus.ready, 1);
         chk("idle_busy", bus.busy, 0);
         chk("idle_pulses", {bus.rx_valid, bus.err}, 0);
      end

      // Directed: 0xA5 to slave 1, and slave 1 answers 0x3C.
      issue(1, 8'hA5, 8'h3C, 1'b1, 1'b0);
      drain();

      // Back-to-back with start held high: 0xFF to slave 0, then 0x00 to slave 3.
      issue(0, 8'hFF, W'($urandom), 1'b1, 1'b1);
      issue(3, 8'h00, W'($urandom), 1'b1, 1'b0);
      drain();

      // Illegal slave indices.
      issue_bad(4);
      issue_bad(7);

      // Abort after the third sclk rise.
      begin
         int   rises = 0;
         int   n = 0;
         logic prev;
         issue(2, W'($urandom), W'($urandom), 1'b0, 1'b0);
         prev = bus.sclk;
         while (rises < 3 && n < 100) begin
            tick();
            n++;
            if (bus.sclk && !prev) rises++;
            prev = bus.sclk;
         end
         chk("abort_saw_3_rises", rises, 3);
         bus.abort = 1'b1;
         tick();
         bus.abort = 1'b0;
         chk("abort_sclk", bus.sclk, 0);
         chk("abort_ss", bus.ss, N);
         chk("abort_mosi", bus.mosi, 0);
         chk("abort_ready", bus.ready, 1);
         chk("abort_rx_valid", bus.rx_valid, 0);
         chk("abort_rx_data", bus.rx_data, last_rx);
         repeat (5) tick();
         chk("abort_rx_data_later", bus.rx_data, last_rx);
      end
      issue(2, 8'h5A, 8'hC3, 1'b1, 1'b0);
      drain();

      // Start during busy (illegal id, so no err may appear), then reset mid-transfer.
      issue(1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      repeat (5) tick();
      bus.start    = 1'b1;
      bus.slave_id = SS_W'(5);
      repeat (3) tick();
      chk("busy_while_started", bus.busy, 1);
      bus.start = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_sclk", bus.sclk, 0);
      chk("mid_rst_mosi", bus.mosi, 0);
      chk("mid_rst_ss", bus.ss, N);
      chk("mid_rst_ready", bus.ready, 1);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_rx_data", bus.rx_data, 0);
      chk("mid_rst_pulses", {bus.rx_valid, bus.err}, 0);
      rst = 1'b0;
      tick();

      // Random mix: legal transfers, some held back-to-back, and rejected ids.
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 5) == 0)
            issue_bad($urandom_range(N, (1 << SS_W) - 1));
         else
            issue($urandom_range(0, N - 1), W'($urandom), W'($urandom), 1'b1,
                  1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) tick();
      end
      bus.start = 1'b0;
      drain();
      repeat (3) tick();
      chk("err_pulse_count", err_seen, err_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI bus master driving `sclk`, `mosi` and an encoded slave-select bus towards up to `N_SLAVES` SPI slave blocks, and capturing `miso`. Sits between the system-side request logic and the SPI slaves, runs entirely in the `clk` domain, and generates `sclk` by division. Performs one full-duplex, MSB-first, SPI mode-0 word transfer per accepted request.

## Interface
- `WIDTH`, 8, bits per transfer (>= 2)
- `N_SLAVES`, 4, number of addressable slaves (>= 1)
- `CLK_DIV`, 2, `clk` cycles per `sclk` half-period (>= 1)
- `SS_W`, `$clog2(N_SLAVES+1)`, derived; width of `ss`

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset rst, synchronous, active-high; clock clk
- `start`  in  1  transfer request, sampled when `ready`=1
- `slave_id`  in  SS_W  target slave index, captured with `start`
- `tx_data`  in  WIDTH  word to transmit, captured with `start`
- `abort`  in  1  cancels the active transfer
- `ready`  out  1  idle, request can be accepted
- `busy`  out  1  transfer in progress (= ~`ready`)
- `rx_data`  out  WIDTH  last completed received word
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated
- `err`  out  1  one-cycle pulse, request rejected
- `sclk`  out  1  SPI clock, idle low
- `mosi`  out  1  master-out data
- `miso`  in  1  slave-out data
- `ss`  out  SS_W  selected slave index; `N_SLAVES` = none selected

## Operation
- Reset values: `sclk`=0, `mosi`=0, `ss`=`N_SLAVES`, `ready`=1, `busy`=0, `rx_data`=0, `rx_valid`=0, `err`=0; FSM in IDLE; counters cleared.
- FSM states: IDLE, XFER, HOLD.
- IDLE: `start`=1 with `slave_id` < `N_SLAVES` -> capture `tx_data` into tx shift register, drive `ss`=`slave_id`, `mosi`=`tx_data[WIDTH-1]`, `sclk`=0, clear bit and phase counters, go to XFER. `start`=1 with `slave_id` >= `N_SLAVES` -> `err` pulse next cycle, stay IDLE, no bus activity.
- XFER: each bit = `CLK_DIV` cycles `sclk`=0 followed by `CLK_DIV` cycles `sclk`=1.
  - At the edge ending a high phase: sample `miso` into rx shift register LSB (shift left), drive `sclk`=0, advance `mosi` to the next tx bit (MSB first).
  - After bit `WIDTH-1` high phase: `sclk`=0, `mosi` holds last bit, go to HOLD.
- HOLD: `CLK_DIV` cycles, `ss` still asserted, `sclk`=0; then `ss`=`N_SLAVES`, `rx_data`<=rx shift register, `rx_valid`=1, `mosi`=0, go to IDLE.
- `ss` changes only while `sclk`=0. `ss` returns to `N_SLAVES` for at least one cycle between transfers (a `start` in the first IDLE cycle is accepted, so the minimum gap is exactly 1 cycle).
- `abort`=1 in XFER/HOLD: next cycle IDLE, `sclk`=0, `ss`=`N_SLAVES`, `mosi`=0, no `rx_valid`, `rx_data` unchanged. `abort` in IDLE is ignored; `abort` and `start` together in IDLE -> `start` wins.
- `start` while busy is ignored (not queued, no `err`).
- `rst` mid-transfer: all outputs return to reset values on the next edge; no `rx_valid`.
- Phase counter width `$clog2(CLK_DIV)`, bit counter width `$clog2(WIDTH)`; no wrap beyond terminal counts.

## Timing
- Start accepted at edge E0 -> `ss`, `mosi` valid and `busy`=1 from E0.
- First `sclk` rise at E0+`CLK_DIV`; k-th rise (k=0..WIDTH-1) at E0+(2k+1)·`CLK_DIV`; `miso` sampled at E0+(2k+2)·`CLK_DIV`.
- `rx_valid`=1, `ready`=1, `ss`=`N_SLAVES` during the cycle beginning at E0+(2·WIDTH+1)·`CLK_DIV`; next `start` may be accepted at that edge's following edge.
- Transfer period with back-to-back requests: (2·WIDTH+1)·`CLK_DIV`+1 cycles.
- `err` asserted the cycle after the rejected request, for one cycle.

## Test plan
- Reset then idle 10 cycles -> `sclk`=0, `ss`=4, `ready`=1, no pulses.
- WIDTH=8, CLK_DIV=2, start `slave_id`=1, `tx_data`=0xA5, `miso` driven by slave model returning 0x3C -> `mosi` bitstream 1,0,1,0,0,1,0,1; 8 `sclk` rises; `rx_valid` 34 cycles after E0 with `rx_data`=0x3C; `ss`=1 throughout, 4 after.
- Back-to-back: two requests (0xFF to slave 0, 0x00 to slave 3) with `start` held high -> `ss` idle for exactly one cycle between; both `rx_valid` pulses 35 cycles apart.
- `slave_id`=4 -> `err` one-cycle pulse, `ss` stays 4, no `sclk` edges.
- `abort` after 3rd `sclk` rise -> next cycle `sclk`=0, `ss`=4, no `rx_valid`, `rx_data` keeps previous value; new request then completes normally.
- `rst` asserted mid-XFER -> all outputs at reset values next cycle; `start` during busy ignored with no `err`.
